handshake_tx_queue: RTL

HANDSHAKE_TX_QUEUE -- requirements
Module: handshake_tx_queue

---
 rtl/handshake_pkg.sv | 9 +
 rtl/sync_ff.sv | 20 ++
 rtl/handshake_tx_queue.sv | 100 ++++++++++
 3 files changed

// File: rtl/handshake_pkg.sv
// handshake_pkg: shared four-phase handshake state encodings for the TX and RX sides
//   hs_state_e : one-hot IDLE / ASSERT / DEASSERT
package handshake_pkg;
   typedef enum logic [2:0] {
      IDLE     = 3'b001,
      ASSERT   = 3'b010,
      DEASSERT = 3'b100
   } hs_state_e;
endpackage

// File: rtl/sync_ff.sv
// sync_ff: multi-flop synchronizer for signals crossing into the clk domain
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears every stage
//   d     : asynchronous input
//   q     : synchronized output (last stage)
module sync_ff #(
   parameter int DW     = 1,
   parameter int STAGES = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] d,
   output logic [DW-1:0] q
);
   logic [STAGES-1:0][DW-1:0] s;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) s <= '0;
      else s <= {s[STAGES-2:0], d};
   assign q = s[STAGES-1];
endmodule

// File: rtl/handshake_tx_queue.sv
// handshake_tx_queue: flop-based TX FIFO draining over a four-phase req/ack handshake
//   clk, rst_n   : TX clock, asynchronous active-low reset
//   push_valid_i : producer offers push_data_i; accepted when push_ready_o is high
//   push_ready_o : queue not full
//   ack_i        : RX acknowledge, asynchronous, synchronized before use
//   req_o        : four-phase request, req_data_o held stable while high
//   level_o      : queued words, not counting the one in flight
//   idle_o       : queue empty and handshake in IDLE
//   done_o       : one-cycle pulse per completed transfer
module handshake_tx_queue
   import handshake_pkg::*;
#(
   parameter int DW          = 32,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_valid_i,
   input  logic [DW-1:0]              push_data_i,
   output logic                       push_ready_o,
   input  logic                       ack_i,
   output logic                       req_o,
   output logic [DW-1:0]              req_data_o,
   output logic [$clog2(DEPTH+1)-1:0] level_o,
   output logic                       idle_o,
   output logic                       done_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);
   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] level_nxt;
   logic          ack_s, push, pop;
   hs_state_e     state;

   sync_ff #(.DW(1), .STAGES(SYNC_STAGES)) u_ack_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (ack_i),
      .q     (ack_s)
   );

   assign push_ready_o = level_o != LW'(DEPTH);
   assign push         = push_valid_i && push_ready_o;
   // a new word is launched only once RX has released the previous ack
   assign pop          = state == IDLE && level_o != '0 && !ack_s;
   assign level_nxt    = level_o + LW'(push) - LW'(pop);

   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= push_data_i;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_o <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         level_o <= level_nxt;
      end

   // idle_o is computed from next-state values so it is a clean flop output
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state      <= IDLE;
         req_o      <= 1'b0;
         req_data_o <= '0;
         done_o     <= 1'b0;
         idle_o     <= 1'b1;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE:
               if (pop) begin
                  req_data_o <= mem[rd_ptr];
                  req_o      <= 1'b1;
                  idle_o     <= 1'b0;
                  state      <= ASSERT;
               end else idle_o <= level_nxt == '0;
            ASSERT:
               if (ack_s) begin
                  req_o <= 1'b0;
                  state <= DEASSERT;
               end
            DEASSERT:
               if (!ack_s) begin
                  done_o <= 1'b1;
                  idle_o <= level_nxt == '0;
                  state  <= IDLE;
               end
            default: begin
               req_o  <= 1'b0;
               idle_o <= level_nxt == '0;
               state  <= IDLE;
            end
         endcase
      end
endmodule
